// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the cached data-memory command port between two requesters.
//   Requester 0 is the load/store unit. Requester 1 is a secondary master.
//   The block accepts one request at a time. It issues a single-cycle
//   MemRead or MemWrite, waits out Stall, then returns rdata and a
//   one-cycle done pulse to the winner. Contested grants alternate
//   round-robin.
//
// Ports
//   clk, rst                  rising-edge clock, async active-low reset
//   reqN_valid/we/addr/wdata  request from port N, held until reqN_ready
//   reqN_ready                combinational accept, only in IDLE
//   reqN_done                 one-cycle completion pulse to the winner
//   rdata                     data of the last completed read
//   busy                      high whenever a transaction is in flight
//   MemRead/MemWrite          one-cycle command pulses to the memory system
//   WordAddress/DataIn        command address/data, held until next grant
//   Stall, DataOut            memory system busy flag and read data
//   err                       watchdog abort flag (MEM_WATCHDOG_EN only)
//
// Build option
//   MEM_WATCHDOG_EN  aborts a WAIT that stalls for WD_CYCLES cycles.
//                    The done pulse then carries err=1 and rdata=0.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; arbitrate and grant in the same cycle
// ISSUE | drive MemRead or MemWrite for exactly one cycle
// WAIT0 | memory registers Stall one cycle late, so Stall is ignored here
// WAIT  | hold while Stall=1; capture DataOut for reads when Stall drops
// DONE  | pulse the winner's done (and err after a watchdog abort)
module dmem_port_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int WD_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] WordAddress,
  output logic [DATA_W-1:0] DataIn,
  input  logic              Stall,
  input  logic [DATA_W-1:0] DataOut
`ifdef MEM_WATCHDOG_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [2:0] {
    stIdle,
    stIssue,
    stWait0,
    stWait,
    stDone
  } stateT;

  stateT state, nextState;
  logic  lastGrant;
  logic  winner;
  logic  latWe;
  logic  grantNow;
  logic  grantPort;
  logic  wdExpire;

  // A watchdog limit of zero would make the abort compare meaningless.
  if (WD_CYCLES < 1) begin : gBadWdCycles
    $error("dmem_port_arbiter: WD_CYCLES must be at least 1");
  end

`ifdef MEM_WATCHDOG_EN
  localparam int WD_W = (WD_CYCLES > 255) ? $clog2(WD_CYCLES + 1) : 8;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

  logic [WD_W-1:0] wdCnt;
  logic            errQ;

  // The abort fires on the stalled WAIT cycle that brings the count to WD_CYCLES.
  assign wdExpire = (state == stWait) && Stall && (wdCnt == WD_LAST);
  assign err      = errQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdCnt <= '0;
      errQ  <= 1'b0;
    end else begin
      // WAIT is only ever entered from WAIT0, so clearing there clears on entry.
      if (state == stWait0) begin
        wdCnt <= '0;
      end else if (state == stWait && Stall) begin
        wdCnt <= wdCnt + 1'b1;
      end
      errQ <= wdExpire;
    end
  end
`else
  assign wdExpire = 1'b0;
`endif

  always_comb begin
    nextState  = state;
    grantNow   = 1'b0;
    grantPort  = 1'b0;
    unique case (state)
      stIdle: begin
        // The rst term keeps ready low while reset is asserted with valid high.
        if (rst && (req0_valid || req1_valid)) begin
          grantNow  = 1'b1;
          grantPort = (req0_valid && req1_valid) ? ~lastGrant : req1_valid;
          nextState = stIssue;
        end
      end
      stIssue: nextState = stWait0;
      stWait0: nextState = stWait;
      stWait: begin
        if (!Stall || wdExpire) begin
          nextState = stDone;
        end
      end
      stDone:  nextState = stIdle;
      default: nextState = stIdle;
    endcase
  end

  assign req0_ready = grantNow && !grantPort;
  assign req1_ready = grantNow && grantPort;
  assign req0_done  = (state == stDone) && !winner;
  assign req1_done  = (state == stDone) && winner;
  assign busy       = (state != stIdle);
  assign MemRead    = (state == stIssue) && !latWe;
  assign MemWrite   = (state == stIssue) && latWe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= stIdle;
      lastGrant   <= 1'b1;
      winner      <= 1'b0;
      latWe       <= 1'b0;
      WordAddress <= '0;
      DataIn      <= '0;
      rdata       <= '0;
    end else begin
      state <= nextState;
      if (grantNow) begin
        lastGrant   <= grantPort;
        winner      <= grantPort;
        latWe       <= grantPort ? req1_we : req0_we;
        WordAddress <= grantPort ? req1_addr : req0_addr;
        DataIn      <= grantPort ? req1_wdata : req0_wdata;
      end
      if (state == stWait && !Stall && !latWe) begin
        rdata <= DataOut;
      end else if (wdExpire) begin
        rdata <= '0;
      end
    end
  end

endmodule
